wta_first_spike: RTL and testbench

//  Downstream consumer of the shared delay-memory group: watches WIDTH delayed pulse lines.
//  Per gamma cycle, selects the first rising edge (1-winner-take-all, lateral inhibition).
//  Re-emits a PULSE_WIDTH pulse on the winning line only; all other lines are inhibited.

---
 rtl/wta_first_spike_pkg.sv | 24 ++
 rtl/wta_first_spike_if.sv | 30 +++
 rtl/wta_first_spike_encoder.sv | 22 ++
 rtl/wta_first_spike.sv | 134 +++++++++++++
 tb/tb_wta_first_spike.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/wta_first_spike_pkg.sv
// Shared types and width helpers for the first-spike winner-take-all block.
package temporal_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        FIRE    = 2'd2,
        INHIBIT = 2'd3
    } wta_state_t;

    // Widest index needed for n distinct values, never below one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int GAMMA_CYCLE_WIDTH_DEF = 16;
    localparam int PULSE_WIDTH_DEF       = 8;
    localparam int WIDTH_DEF             = 128;

    localparam int IDX_W = width_of(WIDTH_DEF);
    localparam int T_W   = width_of(GAMMA_CYCLE_WIDTH_DEF);
    localparam int P_W   = width_of(PULSE_WIDTH_DEF + 1);

endpackage

// File: rtl/wta_first_spike_if.sv
// Pulse-line bundle between the delay group side and the winner-take-all stage.
interface wta_first_spike_if
    import temporal_pkg::*;
#(
    parameter int GAMMA_CYCLE_WIDTH = GAMMA_CYCLE_WIDTH_DEF,
    parameter int WIDTH             = WIDTH_DEF
) ();

    localparam int IDX_BITS = width_of(WIDTH);
    localparam int T_BITS   = width_of(GAMMA_CYCLE_WIDTH);

    logic                grst;
    logic [WIDTH-1:0]    in;
    logic [WIDTH-1:0]    out;
    logic                winner_valid;
    logic [IDX_BITS-1:0] winner_idx;
    logic [T_BITS-1:0]   winner_time;
    logic                gamma_done;

    modport master (
        output grst, in,
        input  out, winner_valid, winner_idx, winner_time, gamma_done
    );

    modport slave (
        input  grst, in,
        output out, winner_valid, winner_idx, winner_time, gamma_done
    );

endinterface

// File: rtl/wta_first_spike_encoder.sv
// Combinational priority encoder: reports whether any bit is set and the lowest set index.
module first_one_encoder #(
    parameter int WIDTH = 128,
    parameter int IDX_W = 7
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic             any_o,
    output logic [IDX_W-1:0] idx_o
);

    always_comb begin
        any_o = |vec_i;
        idx_o = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/wta_first_spike.sv
// First-spike winner-take-all: per gamma cycle, re-emits a fixed-length pulse on the earliest rising line.
module wta_first_spike
    import temporal_pkg::*;
#(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    parameter int WIDTH             = 128
) (
    input  logic             aclk,
    input  logic             rst_n,
    wta_first_spike_if.slave bus
);

    localparam int IDX_BITS = width_of(WIDTH);
    localparam int T_BITS   = width_of(GAMMA_CYCLE_WIDTH);
    localparam int P_BITS   = width_of(PULSE_WIDTH + 1);

    localparam logic [T_BITS-1:0] T_LAST     = T_BITS'(GAMMA_CYCLE_WIDTH - 1);
    localparam logic [P_BITS-1:0] PULSE_LOAD = P_BITS'(PULSE_WIDTH - 1);

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_ARMED   = ARMED;
    localparam logic [1:0] ST_FIRE    = FIRE;
    localparam logic [1:0] ST_INHIBIT = INHIBIT;

    logic [1:0]          state_q, state_d;
    logic [T_BITS-1:0]   t_q, t_d;
    logic [P_BITS-1:0]   pcnt_q, pcnt_d;
    logic [WIDTH-1:0]    prev_q;
    logic [WIDTH-1:0]    out_q, out_d;
    logic                valid_q, valid_d;
    logic [IDX_BITS-1:0] idx_q, idx_d;
    logic [T_BITS-1:0]   time_q, time_d;
    logic                done_q, done_d;

    logic [WIDTH-1:0]    rise;
    logic                rise_any;
    logic [IDX_BITS-1:0] rise_idx;

    // A level already high in the previous cycle is never treated as a spike.
    assign rise = bus.in & ~prev_q;

    first_one_encoder #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_BITS)
    ) u_encoder (
        .vec_i (rise),
        .any_o (rise_any),
        .idx_o (rise_idx)
    );

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        pcnt_d  = pcnt_q;
        out_d   = out_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        time_d  = time_q;

        if (bus.grst) begin
            t_d     = '0;
            state_d = ST_ARMED;
            out_d   = '0;
            valid_d = 1'b0;
        end else if (state_q == ST_IDLE) begin
            t_d = '0;
        end else if (t_q == T_LAST) begin
            // End of gamma: truncate any pulse and re-arm for the next cycle.
            t_d     = '0;
            state_d = ST_ARMED;
            out_d   = '0;
            valid_d = 1'b0;
        end else begin
            t_d = t_q + T_BITS'(1);
            case (state_q)
                ST_ARMED: begin
                    if (rise_any) begin
                        idx_d   = rise_idx;
                        time_d  = t_q;
                        valid_d = 1'b1;
                        out_d   = {{(WIDTH-1){1'b0}}, 1'b1} << rise_idx;
                        pcnt_d  = PULSE_LOAD;
                        state_d = ST_FIRE;
                    end
                end
                ST_FIRE: begin
                    if (pcnt_q == '0) begin
                        out_d   = '0;
                        state_d = ST_INHIBIT;
                    end else begin
                        pcnt_d = pcnt_q - P_BITS'(1);
                    end
                end
                default: begin
                    out_d = '0;
                end
            endcase
        end

        done_d = (t_d == T_LAST);
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            pcnt_q  <= '0;
            prev_q  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            time_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            pcnt_q  <= pcnt_d;
            prev_q  <= bus.in;
            out_q   <= out_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            time_q  <= time_d;
            done_q  <= done_d;
        end
    end

    assign bus.out          = out_q;
    assign bus.winner_valid = valid_q;
    assign bus.winner_idx   = idx_q;
    assign bus.winner_time  = time_q;
    assign bus.gamma_done   = done_q;

endmodule

// File: tb/tb_wta_first_spike.sv
// Directed bench for wta_first_spike with a per-cycle reference model and literal spot checks.
module tb_wta_first_spike;

    localparam int G = 16;
    localparam int P = 8;
    localparam int W = 128;

    logic aclk;
    logic rst_n;

    int vectors;
    int miscompares;

    wta_first_spike_if #(.GAMMA_CYCLE_WIDTH(G), .WIDTH(W)) bus ();

    wta_first_spike #(
        .GAMMA_CYCLE_WIDTH (G),
        .PULSE_WIDTH       (P),
        .WIDTH             (W)
    ) dut (
        .aclk  (aclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Reference model: gamma time, whether a winner exists, who and when.
    logic [3:0]   m_t;
    logic [W-1:0] m_prev;
    logic         m_active;
    logic         m_valid;
    logic [6:0]   m_idx;
    logic [3:0]   m_time;
    logic         m_done;

    always @(posedge aclk or negedge rst_n) begin : model
        logic [W-1:0] rise;
        int           first;
        int           nt;
        logic         nvalid;
        logic         nactive;
        logic [6:0]   nidx;
        logic [3:0]   ntime;
        if (!rst_n) begin
            m_t      <= '0;
            m_prev   <= '0;
            m_active <= 1'b0;
            m_valid  <= 1'b0;
            m_idx    <= '0;
            m_time   <= '0;
            m_done   <= 1'b0;
        end else begin
            rise  = bus.in & ~m_prev;
            first = -1;
            for (int i = 0; i < W; i++) begin
                if (rise[i]) begin
                    first = i;
                    break;
                end
            end
            nt      = int'(m_t);
            nvalid  = m_valid;
            nactive = m_active;
            nidx    = m_idx;
            ntime   = m_time;
            if (bus.grst) begin
                nt      = 0;
                nactive = 1'b1;
                nvalid  = 1'b0;
            end else if (!m_active) begin
                nt = 0;
            end else if (int'(m_t) == G - 1) begin
                nt     = 0;
                nvalid = 1'b0;
            end else begin
                if (!m_valid && first >= 0) begin
                    nvalid = 1'b1;
                    nidx   = 7'(first);
                    ntime  = m_t;
                end
                nt = int'(m_t) + 1;
            end
            m_prev   <= bus.in;
            m_t      <= 4'(nt);
            m_active <= nactive;
            m_valid  <= nvalid;
            m_idx    <= nidx;
            m_time   <= ntime;
            m_done   <= (nt == G - 1);
        end
    end

    // Output is the winner's one-hot for the P cycles after its capture, cut at the gamma end.
    always @(negedge aclk) begin : compare
        logic [W-1:0] exp_out;
        exp_out = '0;
        if (m_valid && (int'(m_t) > int'(m_time)) && (int'(m_t) <= int'(m_time) + P)) begin
            exp_out[m_idx] = 1'b1;
        end
        vectors++;
        if (bus.out !== exp_out || bus.winner_valid !== m_valid || bus.winner_idx !== m_idx ||
            bus.winner_time !== m_time || bus.gamma_done !== m_done) begin
            miscompares++;
            $display("FAIL cycle_model @%0t: out=%0h/%0h valid=%0b/%0b idx=%0d/%0d time=%0d/%0d done=%0b/%0b (got/expected)",
                     $time, bus.out, exp_out, bus.winner_valid, m_valid, bus.winner_idx, m_idx,
                     bus.winner_time, m_time, bus.gamma_done, m_done);
        end
    end

    task automatic lit(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic adv(input int n);
        repeat (n) cyc();
    endtask

    // Leaves the bench in gamma cycle t=0.
    task automatic start_gamma();
        bus.grst = 1'b1;
        cyc();
        bus.grst = 1'b0;
    endtask

    localparam logic [W-1:0] ONE = 128'h1;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus.grst    = 1'b0;
        bus.in      = '0;
        #2;
        lit("reset_out",   bus.out,          '0);
        lit("reset_valid", bus.winner_valid, '0);
        lit("reset_idx",   bus.winner_idx,   '0);
        lit("reset_time",  bus.winner_time,  '0);
        lit("reset_done",  bus.gamma_done,   '0);
        adv(2);
        rst_n = 1'b1;
        adv(2);

        // 1: single rise on line 5 at t=3
        start_gamma();
        adv(3);
        bus.in[5] = 1'b1;
        adv(1);
        lit("t1_out_first", bus.out,          ONE << 5);
        lit("t1_idx",       bus.winner_idx,   7'd5);
        lit("t1_time",      bus.winner_time,  4'd3);
        lit("t1_valid",     bus.winner_valid, 1'b1);
        adv(7);
        lit("t1_out_last",  bus.out,          ONE << 5);
        adv(1);
        lit("t1_out_off",   bus.out,          '0);
        adv(2);
        lit("t1_done_t14",  bus.gamma_done,   1'b0);
        adv(1);
        lit("t1_done_t15",  bus.gamma_done,   1'b1);
        adv(1);
        lit("t1_valid_next", bus.winner_valid, 1'b0);
        $display("test1 done: single rise, vectors=%0d", vectors);

        // 2: tie between lines 7 and 2 at t=6
        bus.in = '0;
        adv(6);
        bus.in[7] = 1'b1;
        bus.in[2] = 1'b1;
        adv(1);
        lit("t2_idx",       bus.winner_idx, 7'd2);
        lit("t2_out_first", bus.out,        ONE << 2);
        adv(7);
        lit("t2_out_t14",   bus.out,        ONE << 2);
        adv(1);
        lit("t2_out_t15",   bus.out,        '0);
        adv(1);
        $display("test2 done: tie, vectors=%0d", vectors);

        // 3: later rise on line 9 is inhibited
        bus.in = '0;
        adv(2);
        bus.in[1] = 1'b1;
        adv(8);
        bus.in[9] = 1'b1;
        adv(1);
        lit("t3_out",  bus.out,        '0);
        lit("t3_idx",  bus.winner_idx, 7'd1);
        lit("t3_time", bus.winner_time, 4'd2);
        adv(5);
        $display("test3 done: inhibition, vectors=%0d", vectors);

        // 4: late rise truncated at the boundary; rise at t=15 ignored
        bus.in = '0;
        adv(12);
        bus.in[4] = 1'b1;
        adv(3);
        lit("t4_out_t15", bus.out, ONE << 4);
        adv(1);
        lit("t4_out_t0",   bus.out,          '0);
        lit("t4_valid_t0", bus.winner_valid, 1'b0);
        bus.in = '0;
        adv(15);
        bus.in[3] = 1'b1;
        adv(2);
        lit("t4_late_valid", bus.winner_valid, 1'b0);
        $display("test4 done: truncation, vectors=%0d", vectors);

        // 5: quiet gamma with line 3 held high from before
        adv(14);
        lit("t5_done",  bus.gamma_done,   1'b1);
        lit("t5_valid", bus.winner_valid, 1'b0);
        adv(1);
        $display("test5 done: quiet gamma, vectors=%0d", vectors);

        // 6a: asynchronous reset mid-pulse, then rises ignored while idle
        bus.in = '0;
        adv(2);
        bus.in[6] = 1'b1;
        adv(4);
        lit("t6_out_before", bus.out, ONE << 6);
        #2;
        rst_n = 1'b0;
        #1;
        lit("t6_out_async", bus.out, '0);
        cyc();
        rst_n = 1'b1;
        bus.in = '0;
        adv(1);
        bus.in[8] = 1'b1;
        adv(2);
        lit("t6_idle_valid", bus.winner_valid, 1'b0);
        lit("t6_idle_out",   bus.out,          '0);

        // 6b: grst mid-pulse re-arms immediately
        start_gamma();
        bus.in = '0;
        adv(2);
        bus.in[10] = 1'b1;
        adv(5);
        bus.grst = 1'b1;
        adv(1);
        bus.grst = 1'b0;
        lit("t6_grst_out",   bus.out,          '0);
        lit("t6_grst_valid", bus.winner_valid, 1'b0);
        lit("t6_grst_idx",   bus.winner_idx,   7'd10);
        adv(3);
        bus.in[11] = 1'b1;
        adv(1);
        lit("t6_rearm_idx",  bus.winner_idx,  7'd11);
        lit("t6_rearm_time", bus.winner_time, 4'd3);
        lit("t6_rearm_out",  bus.out,         ONE << 11);
        adv(13);
        $display("test6 done: reset and grst, vectors=%0d", vectors);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
